// File: rtl/bilateral_mul_sched_pkg.sv
// Shared constants and types for the bilateral filter weight scheduler.
// Lane-sum width is derived here so adder trees and accumulators agree.
package bilateral_mul_sched_pkg;

    localparam int TAPS   = 121;
    localparam int LANES  = 11;
    localparam int GROUPS = TAPS / LANES;
    localparam int P_W    = 21;
    localparam int ACC_W  = 28;
    localparam int CNT_W  = 16;
    localparam int GRP_W  = 4;

    function automatic int lane_sum_width(input int p_w, input int lanes);
        return p_w + $clog2(lanes);
    endfunction

    localparam int LS_W = lane_sum_width(P_W, LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bilateral_mul_sched_if.sv
// Handshake and bank-facing signal bundle of the weight scheduler.
// master = scheduler side, slave = window buffer / bank / divider side.
interface bilateral_mul_sched_if #(
    parameter int CNT_W = bilateral_mul_sched_pkg::CNT_W
);
    import bilateral_mul_sched_pkg::*;

    logic                   win_valid;
    logic                   win_ready;
    logic                   mul_en;
    logic [GRP_W-1:0]       grp_idx;
    logic [LANES*P_W-1:0]   prod_in;
    logic                   wsum_valid;
    logic [ACC_W-1:0]       wsum;
    logic                   wsum_ready;
    logic                   busy;
    logic [CNT_W-1:0]       win_cnt;

    modport master (
        input  win_valid, prod_in, wsum_ready,
        output win_ready, mul_en, grp_idx, wsum_valid, wsum, busy, win_cnt
    );

    modport slave (
        output win_valid, prod_in, wsum_ready,
        input  win_ready, mul_en, grp_idx, wsum_valid, wsum, busy, win_cnt
    );

endinterface

// File: rtl/bilateral_mul_sched_mul_lane_sum.sv
// Reduces LANES unsigned products to one zero-extended lane sum.
// Purely combinational, zero latency; no flow control.
module mul_lane_sum
    import bilateral_mul_sched_pkg::*;
#(
    parameter int N_LANES = LANES,
    parameter int PW      = P_W,
    parameter int SW      = LS_W
) (
    input  logic [N_LANES*PW-1:0] prod_i,
    output logic [SW-1:0]         sum_o
);

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < N_LANES; i++) begin
            sum_o = sum_o + SW'(prod_i[i*PW +: PW]);
        end
    end

endmodule

// File: rtl/bilateral_mul_sched.sv
// Steps the g x h multiplier bank through all tap groups and sums the products.
// Latency: window accept -> wsum_valid is GROUPS+1 cycles; holds wsum until wsum_ready.
module bilateral_mul_sched
    import bilateral_mul_sched_pkg::*;
#(
    parameter int CNT_W = bilateral_mul_sched_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bilateral_mul_sched_if.master bus
);

    state_e             state_q, state_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   wsum_q, wsum_d;
    logic               wsum_vld_q, wsum_vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mul_en_q, mul_en_d;
    logic               win_rdy;
    logic [LS_W-1:0]    lane_sum;
    logic [ACC_W-1:0]   acc_plus;

    mul_lane_sum #(
        .N_LANES (LANES),
        .PW      (P_W),
        .SW      (LS_W)
    ) u_lane_sum (
        .prod_i (bus.prod_in),
        .sum_o  (lane_sum)
    );

    assign acc_plus = acc_q + ACC_W'(lane_sum);

    always_comb begin
        state_d    = state_q;
        grp_d      = grp_q;
        acc_d      = acc_q;
        wsum_d     = wsum_q;
        wsum_vld_d = wsum_vld_q;
        cnt_d      = cnt_q;
        win_rdy    = 1'b0;

        unique case (state_q)
            IDLE: begin
                win_rdy = 1'b1;
                if (bus.win_valid) begin
                    acc_d   = '0;
                    grp_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_plus;
                grp_d = grp_q + GRP_W'(1);
                if (grp_q == GRP_W'(GROUPS - 1)) begin
                    wsum_d     = acc_plus;
                    wsum_vld_d = 1'b1;
                    grp_d      = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // Next window may only start in the same cycle the sum leaves.
                win_rdy = bus.wsum_ready;
                if (bus.wsum_ready) begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    wsum_vld_d = 1'b0;
                    if (bus.win_valid) begin
                        acc_d   = '0;
                        grp_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        mul_en_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grp_q      <= '0;
            acc_q      <= '0;
            wsum_q     <= '0;
            wsum_vld_q <= 1'b0;
            cnt_q      <= '0;
            mul_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grp_q      <= grp_d;
            acc_q      <= acc_d;
            wsum_q     <= wsum_d;
            wsum_vld_q <= wsum_vld_d;
            cnt_q      <= cnt_d;
            mul_en_q   <= mul_en_d;
        end
    end

    assign bus.win_ready  = win_rdy;
    assign bus.mul_en     = mul_en_q;
    assign bus.grp_idx    = grp_q;
    assign bus.wsum_valid = wsum_vld_q;
    assign bus.wsum       = wsum_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.win_cnt    = cnt_q;

endmodule

// File: tb/tb_bilateral_mul_sched.sv
// Scoreboard bench for bilateral_mul_sched with a behavioural multiplier bank.
module tb_bilateral_mul_sched;
    import bilateral_mul_sched_pkg::*;

    localparam int TB_CNT_W = 6;
    localparam int CNT_MOD  = 1 << TB_CNT_W;
    localparam int M_ONES = 0, M_MAX = 1, M_GRPK = 2;

    logic clk;
    logic rst_n;
    int   mode;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   exp_cnt;
    logic [ACC_W-1:0] exp_q[$];

    bilateral_mul_sched_if #(.CNT_W(TB_CNT_W)) bus ();

    bilateral_mul_sched #(.CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: combinational from grp_idx; junk on every lane while disabled.
    always_comb begin
        bus.prod_in = '0;
        for (int l = 0; l < LANES; l++) begin
            if (!bus.mul_en)
                bus.prod_in[l*P_W +: P_W] = P_W'(12345);
            else if (mode == M_ONES)
                bus.prod_in[l*P_W +: P_W] = P_W'(1);
            else if (mode == M_MAX)
                bus.prod_in[l*P_W +: P_W] = P_W'(2080641);
            else
                bus.prod_in[l*P_W +: P_W] = P_W'(bus.grp_idx);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected sum per wsum handshake.
    always @(negedge clk) begin
        if (rst_n && bus.wsum_valid && bus.wsum_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_wsum: got %0d, expected no output", bus.wsum);
            end else begin
                chk("wsum", 64'(bus.wsum), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.wsum_valid && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_wsum_valid"}, 64'(bus.wsum_valid), 64'd1);
    endtask

    task automatic run_window(input logic [ACC_W-1:0] exp);
        exp_q.push_back(exp);
        bus.win_valid = 1'b1;
        tick();
        bus.win_valid = 1'b0;
        wait_valid("run");
        tick();
        exp_cnt = (exp_cnt + 1) % CNT_MOD;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        n_cmp = 0;
        n_err = 0;
        exp_cnt = 0;
        mode = M_ONES;
        bus.win_valid  = 1'b0;
        bus.wsum_ready = 1'b1;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mul_en",     64'(bus.mul_en),     64'd0);
        chk("rst_grp_idx",    64'(bus.grp_idx),    64'd0);
        chk("rst_wsum_valid", 64'(bus.wsum_valid), 64'd0);
        chk("rst_wsum",       64'(bus.wsum),       64'd0);
        chk("rst_win_cnt",    64'(bus.win_cnt),    64'd0);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        chk("rst_win_ready",  64'(bus.win_ready),  64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: all ones, exact timing of mul_en / grp_idx.
        exp_q.push_back(ACC_W'(121));
        bus.win_valid = 1'b1;
        chk("t1_mul_en_c0", 64'(bus.mul_en), 64'd0);
        tick();
        bus.win_valid = 1'b0;
        for (int k = 0; k < GROUPS; k++) begin
            chk("t1_mul_en_run", 64'(bus.mul_en), 64'd1);
            chk("t1_grp_idx", 64'(bus.grp_idx), 64'(k));
            chk("t1_win_ready_run", 64'(bus.win_ready), 64'd0);
            tick();
        end
        chk("t1_mul_en_c12", 64'(bus.mul_en), 64'd0);
        chk("t1_wsum_valid_c12", 64'(bus.wsum_valid), 64'd1);
        tick();
        exp_cnt = 1;
        chk("t1_win_cnt", 64'(bus.win_cnt), 64'(exp_cnt));
        chk("t1_busy", 64'(bus.busy), 64'd0);

        // 2: worst-case products.
        mode = M_MAX;
        run_window(ACC_W'(251757561));
        chk("t2_win_cnt", 64'(bus.win_cnt), 64'(exp_cnt));

        // 3: downstream stall with a pending window.
        mode = M_ONES;
        bus.wsum_ready = 1'b0;
        exp_q.push_back(ACC_W'(121));
        exp_q.push_back(ACC_W'(121));
        bus.win_valid = 1'b1;
        tick();
        wait_valid("t3");
        for (int s = 0; s < 5; s++) begin
            chk("t3_win_ready", 64'(bus.win_ready), 64'd0);
            chk("t3_mul_en", 64'(bus.mul_en), 64'd0);
            chk("t3_hold_valid", 64'(bus.wsum_valid), 64'd1);
            chk("t3_hold_wsum", 64'(bus.wsum), 64'd121);
            tick();
        end
        bus.wsum_ready = 1'b1;
        #1;
        chk("t3_win_ready_rise", 64'(bus.win_ready), 64'd1);
        tick();
        exp_cnt = exp_cnt + 1;
        bus.win_valid = 1'b0;
        chk("t3_restart_mul_en", 64'(bus.mul_en), 64'd1);
        chk("t3_restart_grp", 64'(bus.grp_idx), 64'd0);
        chk("t3_cnt_mid", 64'(bus.win_cnt), 64'(exp_cnt));
        wait_valid("t3b");
        tick();
        exp_cnt = exp_cnt + 1;
        chk("t3_win_cnt", 64'(bus.win_cnt), 64'(exp_cnt));

        // 4: back-to-back windows, group k lanes = k.
        mode = M_GRPK;
        for (int i = 0; i < 3; i++) exp_q.push_back(ACC_W'(605));
        bus.win_valid = 1'b1;
        tick();
        wait_valid("t4a");
        c1 = cyc;
        tick();
        wait_valid("t4b");
        chk("t4_period1", 64'(cyc - c1), 64'd12);
        c1 = cyc;
        tick();
        wait_valid("t4c");
        chk("t4_period2", 64'(cyc - c1), 64'd12);
        bus.win_valid = 1'b0;
        tick();
        exp_cnt = exp_cnt + 3;
        chk("t4_win_cnt", 64'(bus.win_cnt), 64'(exp_cnt));
        chk("t4_busy", 64'(bus.busy), 64'd0);

        // 5: asynchronous abort mid-window.
        mode = M_ONES;
        bus.win_valid = 1'b1;
        tick();
        bus.win_valid = 1'b0;
        for (int n = 0; n < 20 && bus.grp_idx != 4'd5; n++) tick();
        chk("t5_at_grp5", 64'(bus.grp_idx), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("t5_mul_en", 64'(bus.mul_en), 64'd0);
        chk("t5_grp_idx", 64'(bus.grp_idx), 64'd0);
        chk("t5_busy", 64'(bus.busy), 64'd0);
        chk("t5_wsum_valid", 64'(bus.wsum_valid), 64'd0);
        chk("t5_win_cnt", 64'(bus.win_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_cnt = 0;
        for (int n = 0; n < 15; n++) begin
            chk("t5_no_valid", 64'(bus.wsum_valid), 64'd0);
            tick();
        end
        run_window(ACC_W'(121));
        chk("t5_win_cnt", 64'(bus.win_cnt), 64'(exp_cnt));

        // 6: counter wrap.
        while (exp_cnt != CNT_MOD - 1) run_window(ACC_W'(121));
        chk("t6_cnt_max", 64'(bus.win_cnt), 64'(CNT_MOD - 1));
        run_window(ACC_W'(121));
        chk("t6_cnt_wrap", 64'(bus.win_cnt), 64'd0);

        tick();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
